// File: rtl/bitstream_pkg.sv
// Shared definitions for the stochastic-bitstream neuron.
//   - LFSR_TAPS : Fibonacci maximal-length feedback masks, indexed by width 4..16
//   - state_e   : epoch control FSM states
//   - seed_for  : per-input LFSR seed (never zero)
package bitstream_pkg;

   localparam int unsigned LFSR_MIN_W = 4;
   localparam int unsigned LFSR_MAX_W = 16;

   // Bit k set means stage k+1 feeds the XOR; all polynomials are primitive.
   localparam logic [15:0] LFSR_TAPS [LFSR_MIN_W:LFSR_MAX_W] = '{
      16'h000C,  // 4
      16'h0014,  // 5
      16'h0030,  // 6
      16'h0060,  // 7
      16'h00B8,  // 8
      16'h0110,  // 9
      16'h0240,  // 10
      16'h0500,  // 11
      16'h0829,  // 12
      16'h100D,  // 13
      16'h2015,  // 14
      16'h6000,  // 15
      16'hD008   // 16
   };

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Seed = (idx+1+offset) mod 2^width; zero would lock the XOR LFSR, so map it to 1.
   function automatic logic [15:0] seed_for(input int unsigned idx,
                                            input int unsigned offset,
                                            input int unsigned width);
      int unsigned v;
      v = (idx + 32'd1 + offset) & ((32'd1 << width) - 32'd1);
      if (v == 32'd0) v = 32'd1;
      return 16'(v);
   endfunction

endpackage

// File: rtl/lfsr_sng.sv
// Stochastic number generator: Fibonacci LFSR compared against a weight.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the LFSR)
//   load     : load SEED into the LFSR
//   enable   : advance the LFSR one step
//   value    : unsigned weight to compare against
//   y        : combinational stream bit, (lfsr < value)
module lfsr_sng
   import bitstream_pkg::*;
#(
   parameter int unsigned       WIDTH = 8,
   parameter logic [WIDTH-1:0]  SEED  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] value,
   output logic             y
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS[WIDTH]);

   logic [WIDTH-1:0] lfsr_q, lfsr_d;

   // Next-state: load has priority, otherwise shift in XOR of tapped stages.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = SEED;
      end else if (enable) begin
         lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= '0;
      else     lfsr_q <= lfsr_d;
   end

   assign y = (lfsr_q < value);

endmodule

// File: rtl/stoch_neuron_epoch.sv
// Stochastic-bitstream neuron evaluated over a fixed-length epoch.
// Weight streams (LFSR comparators) AND the input streams, the products are
// summed (OR, or round-robin MUX when STOCH_NEURON_MUX_SUM_EN is defined) and
// activated by a saturating-counter tanh FSM.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin an epoch (only honoured in IDLE)
//   weight_values  : per-input unsigned weights, latched on accepted start
//   neuron_input   : per-input bitstream bits, sampled every RUN cycle
//   busy           : epoch in progress
//   neuron_output  : registered activation bit
//   out_valid      : neuron_output carries an epoch bit
//   ones_count     : number of 1s output this epoch, held until next start
//   done           : one-cycle pulse, ones_count final
// Optional macro: STOCH_NEURON_MUX_SUM_EN (scaled-addition MUX sum).
module stoch_neuron_epoch
   import bitstream_pkg::*;
#(
   parameter  int unsigned INPUT_SIZE  = 4,
   parameter  int unsigned WEIGHT_LEN  = 8,
   parameter  int unsigned SEED_OFFSET = 0,
   parameter  int unsigned EPOCH_LEN   = 256,
   parameter  int unsigned TANH_STATES = 8,
   localparam int unsigned COUNT_W     = $clog2(EPOCH_LEN + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [INPUT_SIZE-1:0][WEIGHT_LEN-1:0] weight_values,
   input  logic [INPUT_SIZE-1:0]                neuron_input,
   output logic                                 busy,
   output logic                                 neuron_output,
   output logic                                 out_valid,
   output logic [COUNT_W-1:0]                   ones_count,
   output logic                                 done
);

   localparam int unsigned CNT_W = $clog2(EPOCH_LEN);
   localparam int unsigned TS_W  = $clog2(TANH_STATES);

   state_e                                state_q, state_d;
   logic [INPUT_SIZE-1:0][WEIGHT_LEN-1:0] weight_q, weight_d;
   logic [CNT_W-1:0]                      epoch_q, epoch_d;
   logic [TS_W-1:0]                       tanh_q, tanh_d;
   logic [COUNT_W-1:0]                    ones_q, ones_d;
   logic                                  out_q, out_d;
   logic                                  valid_q, valid_d;
   logic                                  busy_q, busy_d;
   logic                                  done_q, done_d;

   logic                  start_acc_c;
   logic                  run_c;
   logic [INPUT_SIZE-1:0] w_c;
   logic [INPUT_SIZE-1:0] p_c;
   logic                  s_c;
   logic                  act_c;

   assign start_acc_c = (state_q == S_IDLE) && start;
   assign run_c       = (state_q == S_RUN);

   // One weight stream generator per input, each with its own seed.
   for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_sng
      lfsr_sng #(
         .WIDTH (WEIGHT_LEN),
         .SEED  (WEIGHT_LEN'(seed_for(i, SEED_OFFSET, WEIGHT_LEN)))
      ) u_sng (
         .clk    (clk),
         .rst    (rst),
         .load   (start_acc_c),
         .enable (run_c),
         .value  (weight_q[i]),
         .y      (w_c[i])
      );
   end

   assign p_c = w_c & neuron_input;

`ifdef STOCH_NEURON_MUX_SUM_EN
   localparam int unsigned SEL_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

   logic [SEL_W-1:0] sel_q, sel_d;

   // Round-robin input select for scaled addition.
   always_comb begin
      sel_d = sel_q;
      if (start_acc_c) begin
         sel_d = '0;
      end else if (run_c) begin
         sel_d = (sel_q == SEL_W'(INPUT_SIZE - 1)) ? '0 : sel_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) sel_q <= '0;
      else     sel_q <= sel_d;
   end

   assign s_c = p_c[sel_q];
`else
   assign s_c = |p_c;
`endif

   assign act_c = (tanh_q >= TS_W'(TANH_STATES / 2));

   // Epoch control, tanh activation and output counting.
   always_comb begin
      state_d  = state_q;
      weight_d = weight_q;
      epoch_d  = epoch_q;
      tanh_d   = tanh_q;
      ones_d   = ones_q;
      out_d    = 1'b0;
      valid_d  = 1'b0;

      if (valid_q && out_q && (ones_q != COUNT_W'(EPOCH_LEN))) begin
         ones_d = ones_q + COUNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               weight_d = weight_values;
               epoch_d  = '0;
               tanh_d   = TS_W'(TANH_STATES / 2);
               ones_d   = '0;
            end
         end
         S_RUN: begin
            out_d   = act_c;
            valid_d = 1'b1;
            if (s_c) begin
               if (tanh_q != TS_W'(TANH_STATES - 1)) tanh_d = tanh_q + TS_W'(1);
            end else begin
               if (tanh_q != '0) tanh_d = tanh_q - TS_W'(1);
            end
            epoch_d = epoch_q + CNT_W'(1);
            if (epoch_q == CNT_W'(EPOCH_LEN - 1)) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         weight_q <= '0;
         epoch_q  <= '0;
         tanh_q   <= '0;
         ones_q   <= '0;
         out_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         weight_q <= weight_d;
         epoch_q  <= epoch_d;
         tanh_q   <= tanh_d;
         ones_q   <= ones_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy          = busy_q;
   assign neuron_output = out_q;
   assign out_valid     = valid_q;
   assign ones_count    = ones_q;
   assign done          = done_q;

endmodule

// File: tb/tb_stoch_neuron_epoch.sv
module tb_stoch_neuron_epoch;

   localparam int EPOCH = 256;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [3:0][7:0] weight_values;
   logic [3:0]      neuron_input;
   logic            busy;
   logic            neuron_output;
   logic            out_valid;
   logic [8:0]      ones_count;
   logic            done;

   stoch_neuron_epoch dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .weight_values (weight_values),
      .neuron_input  (neuron_input),
      .busy          (busy),
      .neuron_output (neuron_output),
      .out_valid     (out_valid),
      .ones_count    (ones_count),
      .done          (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0][7:0] w;
      logic [3:0]      x;
      int              lo;
      int              hi;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   // Results of the latest epoch run.
   int r_ones, r_held, r_valid, r_first, r_last, r_done_cyc, r_done_cnt;
   int r_busy_cnt, r_busy_last, r_zero_viol, r_ones_at1;
   int r_post_busy, r_post_valid, r_post_ones, r_post_done, r_post_out;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 600 && busy; k++) step();
      step();
   endtask

   // Start an epoch in cycle 0 and observe cycles 1..262.
   task automatic run_epoch(input logic [3:0][7:0] w, input logic [3:0] x,
                            input int rst_at, input bit extra_starts);
      r_ones = -1; r_held = -1; r_valid = 0; r_first = 0; r_last = 0;
      r_done_cyc = 0; r_done_cnt = 0; r_busy_cnt = 0; r_busy_last = 0;
      r_zero_viol = 0; r_ones_at1 = -1;
      r_post_busy = -1; r_post_valid = -1; r_post_ones = -1; r_post_done = -1; r_post_out = -1;
      weight_values = w;
      neuron_input  = x;
      start         = 1'b1;
      for (int c = 1; c <= EPOCH + 6; c++) begin
         step();
         start = extra_starts && (c == 50 || c == EPOCH + 2);
         rst   = (rst_at != 0) && (c == rst_at);
         if (busy) begin
            r_busy_cnt++;
            r_busy_last = c;
         end
         if (c == 1) r_ones_at1 = int'(ones_count);
         if (out_valid) begin
            r_valid++;
            if (r_first == 0) r_first = c;
            r_last = c;
         end
         if (!out_valid && neuron_output) r_zero_viol++;
         if (done) begin
            r_done_cnt++;
            r_done_cyc = c;
            r_ones     = int'(ones_count);
         end
         if (rst_at != 0 && c == rst_at + 1) begin
            r_post_busy  = int'(busy);
            r_post_valid = int'(out_valid);
            r_post_ones  = int'(ones_count);
            r_post_done  = int'(done);
            r_post_out   = int'(neuron_output);
         end
      end
      r_held = int'(ones_count);
      start  = 1'b0;
      rst    = 1'b0;
   endtask

   vec_t vecs [5];
   int   ref_ones;

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      weight_values = '0;
      neuron_input  = '0;

      vecs[0] = '{w: {8'h00, 8'h00, 8'h00, 8'h00}, x: 4'b1111, lo: 1,   hi: 1};
      vecs[1] = '{w: {8'h10, 8'hFF, 8'h81, 8'h3C}, x: 4'b0000, lo: 1,   hi: 1};
      vecs[2] = '{w: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, x: 4'b1111, lo: 250, hi: 256};
`ifdef STOCH_NEURON_MUX_SUM_EN
      vecs[3] = '{w: {8'h00, 8'h00, 8'h00, 8'hFF}, x: 4'b1111, lo: 0,   hi: 63};
      vecs[4] = '{w: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, x: 4'b0001, lo: 0,   hi: 63};
`else
      vecs[3] = '{w: {8'h00, 8'h00, 8'h00, 8'hFF}, x: 4'b1111, lo: 250, hi: 256};
      vecs[4] = '{w: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, x: 4'b0001, lo: 250, hi: 256};
`endif

      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_busy",  int'(busy), 0);
      chk("rst_out",   int'(neuron_output), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_ones",  int'(ones_count), 0);
      chk("rst_done",  int'(done), 0);

      // Table-driven epochs.
      for (int k = 0; k < 5; k++) begin
         run_epoch(vecs[k].w, vecs[k].x, 0, 1'b0);
         chk_rng($sformatf("v%0d_ones", k), r_ones, vecs[k].lo, vecs[k].hi);
         chk($sformatf("v%0d_held", k), r_held, r_ones);
         chk($sformatf("v%0d_ones_at1", k), r_ones_at1, 0);
         chk($sformatf("v%0d_valid_cnt", k), r_valid, EPOCH);
         chk($sformatf("v%0d_first_valid", k), r_first, 2);
         chk($sformatf("v%0d_last_valid", k), r_last, EPOCH + 1);
         chk($sformatf("v%0d_done_cyc", k), r_done_cyc, EPOCH + 2);
         chk($sformatf("v%0d_done_cnt", k), r_done_cnt, 1);
         chk($sformatf("v%0d_busy_cnt", k), r_busy_cnt, EPOCH + 2);
         chk($sformatf("v%0d_busy_last", k), r_busy_last, EPOCH + 2);
         chk($sformatf("v%0d_zero_viol", k), r_zero_viol, 0);
         wait_idle();
      end

      // Starts in RUN (cycle 50) and DONE (cycle 258) are ignored.
      run_epoch({8'h20, 8'hC0, 8'h90, 8'h40}, 4'b1011, 0, 1'b1);
      ref_ones = r_ones;
      chk("xs_done_cnt",  r_done_cnt, 1);
      chk("xs_done_cyc",  r_done_cyc, EPOCH + 2);
      chk("xs_busy_cnt",  r_busy_cnt, EPOCH + 2);
      chk("xs_busy_last", r_busy_last, EPOCH + 2);
      chk_rng("xs_ones_rng", r_ones, 0, EPOCH);
      wait_idle();

      // A fresh start in IDLE reproduces the same stream.
      run_epoch({8'h20, 8'hC0, 8'h90, 8'h40}, 4'b1011, 0, 1'b0);
      chk("rerun_ones",     r_ones, ref_ones);
      chk("rerun_done_cnt", r_done_cnt, 1);
      wait_idle();

      // Reset in cycle 100 aborts the epoch.
      run_epoch({8'h20, 8'hC0, 8'h90, 8'h40}, 4'b1011, 100, 1'b0);
      chk("abort_busy",     r_post_busy, 0);
      chk("abort_valid",    r_post_valid, 0);
      chk("abort_ones",     r_post_ones, 0);
      chk("abort_done",     r_post_done, 0);
      chk("abort_out",      r_post_out, 0);
      chk("abort_done_cnt", r_done_cnt, 0);
      chk("abort_held",     r_held, 0);
      wait_idle();

      run_epoch({8'h20, 8'hC0, 8'h90, 8'h40}, 4'b1011, 0, 1'b0);
      chk("post_abort_ones",     r_ones, ref_ones);
      chk("post_abort_done_cyc", r_done_cyc, EPOCH + 2);
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/stoch_neuron_epoch.md
Name: stoch_neuron_epoch

Overview:
- Next-generation stochastic-bitstream neuron with N inputs.
- Per-input weight bitstreams come from seeded LFSR comparators. Products are AND, summed by OR (or MUX, optional), and activated by a saturating-counter tanh FSM.
- Runs a fixed-length evaluation epoch under start/busy/done control and reports the output bitstream plus its ones count.
- Sits in the network layer, one instance per neuron; the layer controller drives `start` and collects `ones_count`.

Parameters:
- INPUT_SIZE, 4: number of input bitstreams, ≥1.
- WEIGHT_LEN, 8: weight/LFSR width, 4..16.
- SEED_OFFSET, 0: added to per-input LFSR seed so neurons decorrelate.
- EPOCH_LEN, 256: RUN cycles per evaluation, ≥2.
- TANH_STATES, 8: activation FSM states; even, ≥2.
- COUNT_W (localparam): $clog2(EPOCH_LEN+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  begin epoch; honoured only in IDLE.
- weight_values  in  [INPUT_SIZE][WEIGHT_LEN]  unsigned weights; latched on accepted start.
- neuron_input  in  [INPUT_SIZE]  input bitstream bits, sampled each RUN cycle.
- busy  out  1  state != IDLE.
- neuron_output  out  1  registered activation bitstream bit.
- out_valid  out  1  neuron_output carries an epoch bit.
- ones_count  out  COUNT_W  count of 1s output this epoch; held until next start.
- done  out  1  one-cycle pulse; ones_count final.

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst high at a clk edge): state IDLE. All outputs 0; weights, LFSRs, tanh state, counters cleared.
- FSM states IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- start=1 in IDLE at cycle 0:
  - Latch weights; load LFSRs with seeds; tanh state = TANH_STATES/2; ones_count=0; epoch counter=0.
  - RUN occupies cycles 1..EPOCH_LEN.
  - DRAIN at EPOCH_LEN+1; DONE at EPOCH_LEN+2 with done=1.
  - IDLE from EPOCH_LEN+3.
- start outside IDLE (including the DONE cycle) is ignored.
- Weight SNG for input i:
  - Fibonacci maximal-length LFSR, width WEIGHT_LEN. Seed = ((i+1+SEED_OFFSET) mod 2^WEIGHT_LEN); seed 0 is replaced by 1.
  - Weight bit w_i = (lfsr_i < weight_reg_i), compared unsigned, using the current LFSR value. LFSR advances every RUN cycle and holds otherwise.
  - weight 0 gives an all-0 stream; weight 2^W-1 gives 1 except when lfsr = all-ones.
- Product p_i = w_i & neuron_input[i] (bitwise, per input). Sum s = OR over p_i.
- Tanh FSM (Moore), state in 0..TANH_STATES-1:
  - act = (state >= TANH_STATES/2).
  - In RUN: s=1 saturating increment, s=0 saturating decrement.
- Output timing:
  - neuron_output <= act and out_valid <= 1 on the edge ending each RUN cycle.
  - Output valid cycles 2..EPOCH_LEN+1 (RUN cycles 2..EPOCH_LEN, plus DRAIN); EPOCH_LEN valid bits exactly.
- ones_count increments on every cycle where out_valid && neuron_output; max EPOCH_LEN, no wrap.
- neuron_output is 0 whenever out_valid is 0.
- Reset mid-epoch: abort immediately, no done; ones_count=0.
- Same seeds and weights give a bit-identical output stream every epoch.

Optional Feature:
- Macro: STOCH_NEURON_MUX_SUM_EN.
- Defined: the sum is scaled addition. s = p[sel], where sel is a round-robin counter 0..INPUT_SIZE-1 that resets to 0 on accepted start and advances each RUN cycle.
- Undefined: OR sum, no sel counter.

Decomposition:
- Package bitstream_pkg:
  - LFSR tap-mask constant table indexed by width 4..16.
  - FSM state enum typedef.
  - Seed-compute function.
- Sub-module lfsr_sng (params WIDTH, SEED; ports clk, rst, load, enable, value, y), generated per input.
- Tanh FSM and counters stay inline.

Test Plan:
- Defaults; weights all 0; inputs all 1 -> stream 1 then 0s; ones_count==1; done exactly at cycle 258.
- Weights arbitrary; inputs all 0 -> ones_count==1; out_valid high for exactly 256 cycles.
- Weights all 255; inputs all 1 -> ones_count ≥250; busy high cycles 1..258; done one cycle.
- start pulsed at cycles 0, 50, 258 -> only cycle-0 start accepted; single done. Start in IDLE afterward begins a fresh epoch with identical count.
- rst high at cycle 100 mid-RUN -> cycle 101: busy=0, out_valid=0, ones_count=0, no done. Rerun gives the same count as an uninterrupted epoch.
- Input0 weight 255 stream 1, inputs 1..3 weight 0 -> OR build: ones_count ≥250; with STOCH_NEURON_MUX_SUM_EN: ones_count <64.
